// File: rtl/downlink_sequencer.sv
// Digital downlink sequencer: double-buffers channel 34/35 words and shifts
// out one order-bit + word1 + word2 + gap frame per DKSTRT, one bit per DKBSNC.
module downlink_sequencer #(
  parameter int unsigned GAP_BITS  = 7,
  parameter int unsigned WORD_BITS = 16
) (
  input  logic                 CLOCK,
  input  logic                 rst_,
  input  logic                 GOJAM,
  input  logic                 WCH34_,
  input  logic                 WCH35_,
  input  logic [WORD_BITS-1:0] CHWL_,
  input  logic                 DKSTRT,
  input  logic                 DKBSNC,
  output logic                 DKDATA,
  output logic                 DKDAT_,
  output logic                 ORDRBT,
  output logic [4:0]           DKCTR,
  output logic                 BUSY,
  output logic                 DNRPT,
  output logic                 SYNERR
);

  typedef enum logic [2:0] {IDLE, ORDER, WORD1, WORD2, GAP} state_t;

  localparam logic [4:0] CTR_TOP = 5'(WORD_BITS - 1);
  localparam logic [4:0] GAP_TOP = 5'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  state_t               state, state_n;
  logic [WORD_BITS-1:0] buf34, buf35, sr1, sr2, sr1_n, sr2_n;
  logic                 v34, v35, ordbit, ordbit_n;
  logic                 latch, dnrpt_n, data_n;
  logic [4:0]           ctr_n;

  always_comb begin
    state_n = state;
    ctr_n   = DKCTR;
    latch   = 1'b0;
    dnrpt_n = 1'b0;
    case (state)
      IDLE: begin
        // A simultaneous DKBSNC is deliberately ignored here.
        if (DKSTRT) begin
          state_n = ORDER;
          ctr_n   = '0;
          latch   = 1'b1;
        end
      end
      ORDER: begin
        if (DKBSNC) begin
          state_n = WORD1;
          ctr_n   = CTR_TOP;
        end
      end
      WORD1: begin
        if (DKBSNC) begin
          if (DKCTR == '0) begin
            state_n = WORD2;
            ctr_n   = CTR_TOP;
          end else begin
            ctr_n = DKCTR - 5'd1;
          end
        end
      end
      WORD2: begin
        if (DKBSNC) begin
          if (DKCTR == '0) begin
            dnrpt_n = 1'b1;
            if (GAP_BITS == 0) begin
              state_n = IDLE;
              ctr_n   = '0;
            end else begin
              state_n = GAP;
              ctr_n   = GAP_TOP;
            end
          end else begin
            ctr_n = DKCTR - 5'd1;
          end
        end
      end
      GAP: begin
        if (DKBSNC) begin
          if (DKCTR == '0) begin
            state_n = IDLE;
            ctr_n   = '0;
          end else begin
            ctr_n = DKCTR - 5'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        ctr_n   = '0;
      end
    endcase
  end

  // Output bit is derived from next-state values so DKDATA can be registered.
  always_comb begin
    sr1_n    = latch ? buf34 : sr1;
    sr2_n    = latch ? buf35 : sr2;
    ordbit_n = latch ? (v34 & v35) : ordbit;
    data_n   = 1'b0;
    case (state_n)
      ORDER:   data_n = ordbit_n;
      WORD1:   data_n = sr1_n[ctr_n[3:0]];
      WORD2:   data_n = sr2_n[ctr_n[3:0]];
      default: data_n = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!rst_ || GOJAM) begin
      state  <= IDLE;
      buf34  <= '0;
      buf35  <= '0;
      sr1    <= '0;
      sr2    <= '0;
      v34    <= 1'b0;
      v35    <= 1'b0;
      ordbit <= 1'b0;
      DKCTR  <= '0;
      DKDATA <= 1'b0;
      DKDAT_ <= 1'b1;
      ORDRBT <= 1'b0;
      BUSY   <= 1'b0;
      DNRPT  <= 1'b0;
      SYNERR <= 1'b0;
    end else begin
      state  <= state_n;
      sr1    <= sr1_n;
      sr2    <= sr2_n;
      ordbit <= ordbit_n;
      DKCTR  <= ctr_n;
      DKDATA <= data_n;
      DKDAT_ <= ~data_n;
      ORDRBT <= (state_n == ORDER);
      BUSY   <= (state_n != IDLE);
      DNRPT  <= dnrpt_n;
      if (!WCH34_) buf34 <= ~CHWL_;
      if (!WCH35_) buf35 <= ~CHWL_;
      // A write in the latch cycle wins over the latch clearing the flag.
      if (!WCH34_)    v34 <= 1'b1;
      else if (latch) v34 <= 1'b0;
      if (!WCH35_)    v35 <= 1'b1;
      else if (latch) v35 <= 1'b0;
      if (DKSTRT && state != IDLE) SYNERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_downlink_sequencer.sv
// Scoreboard bench for downlink_sequencer: default-gap instance plus a
// GAP_BITS=0 instance sharing the same stimulus.
module tb_downlink_sequencer;

  logic        CLOCK = 1'b0;
  logic        rst_ = 1'b0, GOJAM = 1'b0, WCH34_ = 1'b1, WCH35_ = 1'b1;
  logic [15:0] CHWL_ = '1;
  logic        DKSTRT = 1'b0, DKBSNC = 1'b0;

  logic       d0, dn0, ob0, busy0, dnrpt0, syn0;
  logic [4:0] ctr0;
  logic       d1, dn1, ob1, busy1, dnrpt1, syn1;
  logic [4:0] ctr1;

  downlink_sequencer u0 (
    .CLOCK(CLOCK), .rst_(rst_), .GOJAM(GOJAM), .WCH34_(WCH34_), .WCH35_(WCH35_),
    .CHWL_(CHWL_), .DKSTRT(DKSTRT), .DKBSNC(DKBSNC), .DKDATA(d0), .DKDAT_(dn0),
    .ORDRBT(ob0), .DKCTR(ctr0), .BUSY(busy0), .DNRPT(dnrpt0), .SYNERR(syn0)
  );

  downlink_sequencer #(.GAP_BITS(0)) u1 (
    .CLOCK(CLOCK), .rst_(rst_), .GOJAM(GOJAM), .WCH34_(WCH34_), .WCH35_(WCH35_),
    .CHWL_(CHWL_), .DKSTRT(DKSTRT), .DKBSNC(DKBSNC), .DKDATA(d1), .DKDAT_(dn1),
    .ORDRBT(ob1), .DKCTR(ctr1), .BUSY(busy1), .DNRPT(dnrpt1), .SYNERR(syn1)
  );

  always #5 CLOCK = ~CLOCK;

  int unsigned tests = 0, fails = 0;
  int unsigned strobe_cnt = 0;
  int unsigned dn_cnt = 0, dn_at = 0;
  logic        q[$];
  logic        exp_bit;

  always @(negedge CLOCK) if (dnrpt0) begin
    dn_cnt++;
    dn_at = strobe_cnt;
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic write34(input logic [15:0] w);
    WCH34_ = 1'b0; CHWL_ = ~w; tick(); WCH34_ = 1'b1; CHWL_ = '1;
  endtask

  task automatic write35(input logic [15:0] w);
    WCH35_ = 1'b0; CHWL_ = ~w; tick(); WCH35_ = 1'b1; CHWL_ = '1;
  endtask

  task automatic start();
    DKSTRT = 1'b1; tick(); DKSTRT = 1'b0;
  endtask

  task automatic strobe(input int unsigned idle_cycles);
    DKBSNC = 1'b1; strobe_cnt++; tick(); DKBSNC = 1'b0;
    repeat (idle_cycles) tick();
  endtask

  task automatic push_frame(input logic ordb, input logic [15:0] w1, input logic [15:0] w2,
                            input int unsigned gap);
    q.push_back(ordb);
    for (int i = 15; i >= 0; i--) q.push_back(w1[i]);
    for (int i = 15; i >= 0; i--) q.push_back(w2[i]);
    for (int unsigned i = 0; i < gap; i++) q.push_back(1'b0);
  endtask

  task automatic test_reset();
    rst_ = 1'b0; WCH34_ = 1'b0; CHWL_ = '0; DKSTRT = 1'b1;
    tick(); tick();
    tests++;
    if ({d0, dn0, ob0, ctr0, busy0, dnrpt0, syn0} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got data=%b n=%b ord=%b ctr=%0d busy=%b dnrpt=%b syn=%b, want 0 1 0 0 0 0 0",
               d0, dn0, ob0, ctr0, busy0, dnrpt0, syn0);
    end
    rst_ = 1'b1; WCH34_ = 1'b1; CHWL_ = '1; DKSTRT = 1'b0;
    tick();
    tests++;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", busy0); end
    // ch34 write during reset must not have set v34 nor loaded buf34
    write35(16'h1111);
    push_frame(1'b0, 16'h0000, 16'h1111, 7);
    start();
    exp_bit = q.pop_front();
    tests++;
    if (d0 !== exp_bit) begin fails++; $display("FAIL reset_v34_order: got %b want %b", d0, exp_bit); end
    for (int k = 1; k <= 40; k++) begin
      strobe(1);
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit || dn0 !== ~exp_bit) begin
          fails++; $display("FAIL reset_frame_bit%0d: got %b/%b want %b", k, d0, dn0, exp_bit);
        end
      end
    end
    tests++;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_frame_end_busy: got %b want 0", busy0); end
  endtask

  task automatic test_full_frame();
    int unsigned dn_before;
    write34(16'hA5C3);
    write35(16'h0F0F);
    push_frame(1'b1, 16'hA5C3, 16'h0F0F, 7);
    dn_before = dn_cnt;
    strobe_cnt = 0;
    start();
    exp_bit = q.pop_front();
    tests++;
    if ({d0, ob0, busy0, ctr0} !== {exp_bit, 1'b1, 1'b1, 5'd0}) begin
      fails++; $display("FAIL full_order: got d=%b ord=%b busy=%b ctr=%0d want %b 1 1 0", d0, ob0, busy0, ctr0, exp_bit);
    end
    for (int k = 1; k <= 40; k++) begin
      strobe(7);
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL full_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
      if (k == 1) begin
        tests++;
        if (ctr0 !== 5'd15 || ob0 !== 1'b0) begin
          fails++; $display("FAIL full_ctr_first: got ctr=%0d ord=%b want 15 0", ctr0, ob0);
        end
      end
      if (k == 39) begin
        tests++;
        if (busy0 !== 1'b1) begin fails++; $display("FAIL full_busy_39: got %b want 1", busy0); end
      end
    end
    tests++;
    if (busy0 !== 1'b0) begin fails++; $display("FAIL full_busy_end: got %b want 0", busy0); end
    tests++;
    if (dn_cnt - dn_before !== 1 || dn_at !== 33) begin
      fails++; $display("FAIL full_dnrpt: got %0d pulses at strobe %0d want 1 at 33", dn_cnt - dn_before, dn_at);
    end
  endtask

  task automatic test_empty_frame();
    write34(16'h1234);
    push_frame(1'b0, 16'h1234, 16'h0F0F, 7);
    start();
    exp_bit = q.pop_front();
    tests++;
    if (d0 !== exp_bit || ob0 !== 1'b1) begin
      fails++; $display("FAIL empty_order: got d=%b ord=%b want %b 1", d0, ob0, exp_bit);
    end
    for (int k = 1; k <= 40; k++) begin
      strobe(0);
      if (k == 1) begin
        tests++;
        if (ob0 !== 1'b0) begin fails++; $display("FAIL empty_ordrbt_len: got %b want 0", ob0); end
      end
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL empty_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
    end
    // v34 was cleared at the previous latch, so writing ch35 alone is not enough
    write35(16'h2222);
    push_frame(1'b0, 16'h1234, 16'h2222, 7);
    start();
    exp_bit = q.pop_front();
    tests++;
    if (d0 !== exp_bit) begin fails++; $display("FAIL empty_v34_cleared: got %b want %b", d0, exp_bit); end
    for (int k = 1; k <= 40; k++) begin
      strobe(0);
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL empty2_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
    end
  endtask

  task automatic test_collisions();
    write34(16'hAAAA);
    write35(16'h5555);
    push_frame(1'b1, 16'hAAAA, 16'h5555, 7);
    DKSTRT = 1'b1; DKBSNC = 1'b1; tick(); DKSTRT = 1'b0; DKBSNC = 1'b0;
    exp_bit = q.pop_front();
    tests++;
    if ({d0, ob0, ctr0} !== {exp_bit, 1'b1, 5'd0}) begin
      fails++; $display("FAIL coll_start_bsnc: got d=%b ord=%b ctr=%0d want %b 1 0", d0, ob0, ctr0, exp_bit);
    end
    for (int k = 1; k <= 40; k++) begin
      strobe(0);
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL coll_a_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
    end
    write34(16'h0001);
    write35(16'h0002);
    push_frame(1'b1, 16'h0001, 16'h0002, 7);
    DKSTRT = 1'b1; WCH35_ = 1'b0; CHWL_ = ~16'h0003; tick();
    DKSTRT = 1'b0; WCH35_ = 1'b1; CHWL_ = '1;
    exp_bit = q.pop_front();
    tests++;
    if (d0 !== exp_bit) begin fails++; $display("FAIL coll_latch_order: got %b want %b", d0, exp_bit); end
    for (int k = 1; k <= 40; k++) begin
      strobe(0);
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL coll_b_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
    end
    write34(16'h0004);
    push_frame(1'b1, 16'h0004, 16'h0003, 7);
    start();
    exp_bit = q.pop_front();
    tests++;
    if (d0 !== exp_bit) begin fails++; $display("FAIL coll_next_order: got %b want %b", d0, exp_bit); end
    for (int k = 1; k <= 40; k++) begin
      strobe(0);
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL coll_c_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
    end
  endtask

  task automatic test_overrun();
    write34(16'h3C3C);
    write35(16'hC3C3);
    push_frame(1'b1, 16'h3C3C, 16'hC3C3, 7);
    start();
    exp_bit = q.pop_front();
    tests++;
    if (d0 !== exp_bit || syn0 !== 1'b0) begin
      fails++; $display("FAIL ovr_order: got d=%b syn=%b want %b 0", d0, syn0, exp_bit);
    end
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) begin
        DKSTRT = 1'b1; tick();
        tests++;
        if (d0 !== exp_bit || ctr0 !== 5'd11 || syn0 !== 1'b1 || ob0 !== 1'b0) begin
          fails++; $display("FAIL ovr_hold: got d=%b ctr=%0d syn=%b ord=%b want %b 11 1 0", d0, ctr0, syn0, ob0, exp_bit);
        end
        strobe(0);
        DKSTRT = 1'b0;
      end else begin
        strobe(0);
      end
      if (k < 40) begin
        exp_bit = q.pop_front();
        tests++;
        if (d0 !== exp_bit) begin fails++; $display("FAIL ovr_bit%0d: got %b want %b", k, d0, exp_bit); end
      end
    end
    tick();
    tests++;
    if (syn0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++; $display("FAIL ovr_sticky: got syn=%b busy=%b want 1 0", syn0, busy0);
    end
  endtask

  task automatic test_abort();
    int unsigned dn_before;
    write34(16'h1357);
    write35(16'h2468);
    push_frame(1'b1, 16'h1357, 16'h2468, 7);
    dn_before = dn_cnt;
    start();
    exp_bit = q.pop_front();
    for (int k = 1; k <= 25; k++) begin
      strobe(0);
      exp_bit = q.pop_front();
      tests++;
      if (d0 !== exp_bit) begin fails++; $display("FAIL abort_bit%0d: got %b want %b", k, d0, exp_bit); end
    end
    tests++;
    if (ctr0 !== 5'd7) begin fails++; $display("FAIL abort_ctr_pre: got %0d want 7", ctr0); end
    q.delete();
    GOJAM = 1'b1; tick(); GOJAM = 1'b0;
    tests++;
    if ({busy0, d0, dn0, ctr0, syn0, dnrpt0} !== {1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL abort_state: got busy=%b d=%b n=%b ctr=%0d syn=%b dnrpt=%b want 0 0 1 0 0 0",
                        busy0, d0, dn0, ctr0, syn0, dnrpt0);
    end
    repeat (10) strobe(0);
    tests++;
    if (dn_cnt !== dn_before || busy0 !== 1'b0) begin
      fails++; $display("FAIL abort_no_dnrpt: got %0d pulses busy=%b want 0 0", dn_cnt - dn_before, busy0);
    end
  endtask

  task automatic test_gap0();
    write34(16'h00FF);
    write35(16'hFF00);
    push_frame(1'b1, 16'h00FF, 16'hFF00, 0);
    start();
    exp_bit = q.pop_front();
    tests++;
    if (d1 !== exp_bit || ob1 !== 1'b1) begin
      fails++; $display("FAIL gap0_order: got d=%b ord=%b want %b 1", d1, ob1, exp_bit);
    end
    for (int k = 1; k <= 33; k++) begin
      strobe(0);
      if (k < 33) begin
        exp_bit = q.pop_front();
        tests++;
        if (d1 !== exp_bit || dnrpt1 !== 1'b0) begin
          fails++; $display("FAIL gap0_bit%0d: got %b dnrpt=%b want %b 0", k, d1, dnrpt1, exp_bit);
        end
      end
    end
    tests++;
    if ({busy1, dnrpt1, d1, ctr1} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
      fails++; $display("FAIL gap0_end: got busy=%b dnrpt=%b d=%b ctr=%0d want 0 1 0 0", busy1, dnrpt1, d1, ctr1);
    end
    tick();
    tests++;
    if (dnrpt1 !== 1'b0) begin fails++; $display("FAIL gap0_pulse_width: got %b want 0", dnrpt1); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_empty_frame();
    test_collisions();
    test_overrun();
    test_abort();
    test_gap0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
